// File: rtl/aes_gcm_pkg.sv
// Shared definitions for the AES-GCM core sequencer: bus widths, FSM encoding
// and the latched command record.
package aes_gcm_pkg;

    localparam int BLK_W = 128;
    localparam int KEY_W = 256;
    localparam int IV_W  = 96;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_KEY,
        ST_IV,
        ST_AAD,
        ST_DATA,
        ST_TAG,
        ST_WAIT,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic              encdec;
        logic              keylen;
        logic [0:KEY_W-1]  key;
        logic [0:IV_W-1]   iv;
    } cmd_t;

    // Encrypt has no expected tag to hand over, so it goes straight to WAIT.
    function automatic state_t post_data_state(input logic encdec);
        return encdec ? ST_WAIT : ST_TAG;
    endfunction

endpackage

// File: rtl/aes_gcm_blkcnt.sv
// Loadable down-counter for AAD / payload block counts; flags empty and
// the final remaining block.
module aes_gcm_blkcnt #(
    parameter int CW = 16
) (
    input  logic          iClk,
    input  logic          iRstn,
    input  logic          iLoad,
    input  logic [CW-1:0] iLoadVal,
    input  logic          iDec,
    output logic          oZero,
    output logic          oLast
);

    logic [CW-1:0] cnt;

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            cnt <= '0;
        end else if (iLoad) begin
            cnt <= iLoadVal;
        end else if (iDec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign oZero = (cnt == '0);
    assign oLast = (cnt == CW'(1));

endmodule

// File: rtl/aes_gcm_ctrl.sv
// AES-GCM command sequencer: latches a command, walks the core through
// init/key/IV/AAD/payload/tag and reports completion and authenticity.
module aes_gcm_ctrl
    import aes_gcm_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic               iClk,
    input  logic               iRstn,
    input  logic               iStart,
    input  logic               iEncdec,
    input  logic               iKeylen,
    input  logic [0:KEY_W-1]   iKey,
    input  logic [0:IV_W-1]    iIV,
    input  logic [CW-1:0]      iAadCnt,
    input  logic [CW-1:0]      iBlkCnt,
    input  logic [0:BLK_W-1]   iData,
    input  logic               iData_valid,
    output logic               oData_ready,
    input  logic [0:BLK_W-1]   iTag,
    input  logic               iTag_valid,
    output logic               oTag_ready,
    output logic               oBusy,
    output logic               oDone,
    output logic               oAuthentic,
    output logic               oErr,
    output logic               oCoreInit,
    output logic               oCoreEncdec,
    output logic               oCoreOpMode,
    output logic [0:KEY_W-1]   oCoreKey,
    output logic               oCoreKey_valid,
    output logic               oCoreKeylen,
    output logic [0:IV_W-1]    oCoreIV,
    output logic               oCoreIV_valid,
    output logic [0:BLK_W-1]   oCoreData,
    output logic               oCoreAad_valid,
    output logic               oCoreAad_last,
    output logic               oCoreBlock_valid,
    output logic               oCoreBlock_last,
    output logic [0:BLK_W-1]   oCoreTag,
    output logic               oCoreTag_valid,
    input  logic               iCoreReady,
    input  logic               iCoreResult_valid,
    input  logic               iCoreTag_valid,
    input  logic               iCoreAuthentic
);

    state_t        state;
    cmd_t          cmd_q;
    logic [CW-1:0] blk_q;
    logic [CW-1:0] res_cnt;
    logic          init_q;
    logic          tag_seen;
    logic          auth_q;
    logic          err_q;

    logic aad_zero, aad_last, blk_zero, blk_last;
    logic start_ok, data_rdy, beat, aad_fire, blk_fire;
    logic key_fire, iv_fire, tag_rdy, tag_fire;
    logic res_match, tag_hit;

    assign start_ok  = (state == ST_IDLE) && iStart;

    // Every core-side strobe is qualified by iCoreReady in the same cycle.
    assign data_rdy  = iCoreReady && (((state == ST_AAD)  && !aad_zero) ||
                                      ((state == ST_DATA) && !blk_zero));
    assign beat      = data_rdy && iData_valid;
    assign aad_fire  = beat && (state == ST_AAD);
    assign blk_fire  = beat && (state == ST_DATA);
    assign key_fire  = (state == ST_KEY) && iCoreReady;
    assign iv_fire   = (state == ST_IV)  && iCoreReady;
    assign tag_rdy   = (state == ST_TAG) && iCoreReady;
    assign tag_fire  = tag_rdy && iTag_valid;
    assign res_match = (res_cnt == blk_q);
    assign tag_hit   = tag_seen || iCoreTag_valid;

    aes_gcm_blkcnt #(.CW(CW)) u_aad_cnt (
        .iClk     (iClk),
        .iRstn    (iRstn),
        .iLoad    (start_ok),
        .iLoadVal (iAadCnt),
        .iDec     (aad_fire),
        .oZero    (aad_zero),
        .oLast    (aad_last)
    );

    aes_gcm_blkcnt #(.CW(CW)) u_blk_cnt (
        .iClk     (iClk),
        .iRstn    (iRstn),
        .iLoad    (start_ok),
        .iLoadVal (iBlkCnt),
        .iDec     (blk_fire),
        .oZero    (blk_zero),
        .oLast    (blk_last)
    );

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            state  <= ST_IDLE;
            cmd_q  <= '0;
            blk_q  <= '0;
            init_q <= 1'b0;
        end else begin
            init_q <= 1'b0;
            case (state)
                ST_IDLE: if (iStart) begin
                    state        <= ST_INIT;
                    init_q       <= 1'b1;
                    cmd_q.encdec <= iEncdec;
                    cmd_q.keylen <= iKeylen;
                    cmd_q.key    <= iKey;
                    cmd_q.iv     <= iIV;
                    blk_q        <= iBlkCnt;
                end
                ST_INIT: if (iCoreReady) state <= ST_KEY;
                ST_KEY:  if (iCoreReady) state <= ST_IV;
                ST_IV:   if (iCoreReady) begin
                    if (!aad_zero)      state <= ST_AAD;
                    else if (!blk_zero) state <= ST_DATA;
                    else                state <= post_data_state(cmd_q.encdec);
                end
                ST_AAD: if (aad_fire && aad_last) begin
                    state <= blk_zero ? post_data_state(cmd_q.encdec) : ST_DATA;
                end
                ST_DATA: if (blk_fire && blk_last) state <= post_data_state(cmd_q.encdec);
                ST_TAG:  if (tag_fire) state <= ST_WAIT;
                ST_WAIT: if (res_match && tag_hit) state <= ST_DONE;
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Results and the core tag may overtake the FSM, so they are tracked
    // independently of the current state.
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            res_cnt  <= '0;
            tag_seen <= 1'b0;
            auth_q   <= 1'b0;
            err_q    <= 1'b0;
        end else if (start_ok) begin
            res_cnt  <= '0;
            tag_seen <= 1'b0;
            auth_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (iCoreResult_valid) begin
                if (res_match) err_q   <= 1'b1;
                else           res_cnt <= res_cnt + 1'b1;
            end
            if (iCoreTag_valid && state != ST_IDLE && !tag_seen) begin
                tag_seen <= 1'b1;
                auth_q   <= cmd_q.encdec ? 1'b1 : iCoreAuthentic;
            end
        end
    end

    assign oBusy            = (state != ST_IDLE);
    assign oDone            = (state == ST_DONE);
    assign oAuthentic       = auth_q;
    assign oErr             = err_q;
    assign oData_ready      = data_rdy;
    assign oTag_ready       = tag_rdy;

    assign oCoreInit        = init_q;
    assign oCoreEncdec      = cmd_q.encdec;
    assign oCoreOpMode      = 1'b0;
    assign oCoreKey         = cmd_q.key;
    assign oCoreKeylen      = cmd_q.keylen;
    assign oCoreKey_valid   = key_fire;
    assign oCoreIV          = cmd_q.iv;
    assign oCoreIV_valid    = iv_fire;
    assign oCoreData        = beat ? iData : '0;
    assign oCoreAad_valid   = aad_fire;
    assign oCoreAad_last    = aad_fire && aad_last;
    assign oCoreBlock_valid = blk_fire;
    assign oCoreBlock_last  = blk_fire && blk_last;
    assign oCoreTag         = tag_fire ? iTag : '0;
    assign oCoreTag_valid   = tag_fire;

endmodule

// File: tb/tb_aes_gcm_ctrl.sv
// Directed bench for aes_gcm_ctrl with a small core model and a beat scoreboard.
module tb_aes_gcm_ctrl;

    localparam int CW = 16;

    logic            iClk = 1'b0;
    logic            iRstn = 1'b0;
    logic            iStart = 1'b0, iEncdec = 1'b0, iKeylen = 1'b0;
    logic [0:255]    iKey = '0;
    logic [0:95]     iIV = '0;
    logic [CW-1:0]   iAadCnt = '0, iBlkCnt = '0;
    logic [0:127]    iData = '0, iTag = '0;
    logic            iData_valid = 1'b0, iTag_valid = 1'b0;
    logic            iCoreReady = 1'b0, iCoreResult_valid = 1'b0;
    logic            iCoreTag_valid = 1'b0, iCoreAuthentic = 1'b0;

    logic            oData_ready, oTag_ready, oBusy, oDone, oAuthentic, oErr;
    logic            oCoreInit, oCoreEncdec, oCoreOpMode, oCoreKey_valid, oCoreKeylen;
    logic [0:255]    oCoreKey;
    logic [0:95]     oCoreIV;
    logic            oCoreIV_valid;
    logic [0:127]    oCoreData, oCoreTag;
    logic            oCoreAad_valid, oCoreAad_last, oCoreBlock_valid, oCoreBlock_last;
    logic            oCoreTag_valid;

    aes_gcm_ctrl #(.CW(CW)) dut (
        .iClk(iClk), .iRstn(iRstn), .iStart(iStart), .iEncdec(iEncdec), .iKeylen(iKeylen),
        .iKey(iKey), .iIV(iIV), .iAadCnt(iAadCnt), .iBlkCnt(iBlkCnt),
        .iData(iData), .iData_valid(iData_valid), .oData_ready(oData_ready),
        .iTag(iTag), .iTag_valid(iTag_valid), .oTag_ready(oTag_ready),
        .oBusy(oBusy), .oDone(oDone), .oAuthentic(oAuthentic), .oErr(oErr),
        .oCoreInit(oCoreInit), .oCoreEncdec(oCoreEncdec), .oCoreOpMode(oCoreOpMode),
        .oCoreKey(oCoreKey), .oCoreKey_valid(oCoreKey_valid), .oCoreKeylen(oCoreKeylen),
        .oCoreIV(oCoreIV), .oCoreIV_valid(oCoreIV_valid), .oCoreData(oCoreData),
        .oCoreAad_valid(oCoreAad_valid), .oCoreAad_last(oCoreAad_last),
        .oCoreBlock_valid(oCoreBlock_valid), .oCoreBlock_last(oCoreBlock_last),
        .oCoreTag(oCoreTag), .oCoreTag_valid(oCoreTag_valid),
        .iCoreReady(iCoreReady), .iCoreResult_valid(iCoreResult_valid),
        .iCoreTag_valid(iCoreTag_valid), .iCoreAuthentic(iCoreAuthentic)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        bit           kind;   // 0 = AAD, 1 = payload
        bit           last;
        logic [127:0] data;
    } exp_t;

    int   checks = 0, failures = 0;
    exp_t q[$];
    logic [127:0] beats [0:15];
    logic [255:0] key_s;
    logic [95:0]  iv_s;
    logic [127:0] tag_s;
    int   cur_aad, cur_blk, idx, res_pend, res_given;
    bit   cur_enc, cur_kl, exp_auth, exp_err, tag_fired, aborted;
    int   n_aad, n_blk, n_alast, n_blast, n_key, n_iv, n_init, n_tagv, n_done, n_viol;
    bit   saw_tr;

    task chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task chk_zero(input string pfx);
        chk({pfx, "_ctrl"}, {oBusy, oDone, oData_ready, oTag_ready, oCoreInit, oCoreEncdec,
                             oCoreOpMode, oCoreKey_valid, oCoreKeylen, oCoreIV_valid,
                             oCoreAad_valid, oCoreAad_last, oCoreBlock_valid, oCoreBlock_last,
                             oCoreTag_valid, oAuthentic, oErr}, '0);
        chk({pfx, "_key"}, oCoreKey, '0);
        chk({pfx, "_iv"}, oCoreIV, '0);
        chk({pfx, "_data"}, oCoreData, '0);
        chk({pfx, "_tag"}, oCoreTag, '0);
    endtask

    // One clock: observe at the falling edge, return just after the rising edge.
    task sample();
        exp_t e;
        @(negedge iClk);
        if (iData_valid && oData_ready) begin
            e.kind = (idx >= cur_aad);
            e.last = e.kind ? (idx == cur_aad + cur_blk - 1) : (idx == cur_aad - 1);
            e.data = beats[idx];
            q.push_back(e);
            idx++;
        end
        if (!iCoreReady && (oCoreKey_valid || oCoreIV_valid || oCoreAad_valid ||
                            oCoreBlock_valid || oCoreTag_valid)) n_viol++;
        if ((oCoreAad_last && !oCoreAad_valid) || (oCoreBlock_last && !oCoreBlock_valid)) n_viol++;
        if (oCoreAad_valid || oCoreBlock_valid) begin
            chk("beat_pending", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("beat", {oCoreAad_valid, oCoreBlock_valid, oCoreAad_last, oCoreBlock_last, oCoreData},
                    {!e.kind, e.kind, !e.kind && e.last, e.kind && e.last, e.data});
            end
        end
        if (oCoreAad_valid)   n_aad++;
        if (oCoreBlock_valid) begin n_blk++; res_pend++; end
        if (oCoreAad_last)    n_alast++;
        if (oCoreBlock_last)  n_blast++;
        if (oCoreKey_valid)   n_key++;
        if (oCoreIV_valid)    n_iv++;
        if (oCoreInit)        n_init++;
        if (oTag_ready)       saw_tr = 1'b1;
        if (oCoreTag_valid) begin
            n_tagv++;
            tag_fired = 1'b1;
            chk("core_tag", oCoreTag, tag_s);
        end
        if (oDone) begin
            n_done++;
            chk("authentic", oAuthentic, exp_auth);
            chk("err_at_done", oErr, exp_err);
            chk("key_held", oCoreKey, key_s);
            chk("iv_held", oCoreIV, iv_s);
            chk("mode_held", {oCoreEncdec, oCoreKeylen, oCoreOpMode}, {cur_enc, cur_kl, 1'b0});
        end
        @(posedge iClk);
        #1;
    endtask

    task run_op(input bit enc, input bit kl, input int aad, input int blk, input bit auth,
                input bit tgl, input bit extra, input bit glitch, input int abort_at);
        bit extra_done, tag_given;
        cur_enc = enc; cur_kl = kl; cur_aad = aad; cur_blk = blk;
        exp_auth = enc ? 1'b1 : auth;
        exp_err  = extra;
        for (int i = 0; i < 8; i++) key_s[i*32 +: 32] = $urandom();
        for (int i = 0; i < 3; i++) iv_s[i*32 +: 32] = $urandom();
        for (int i = 0; i < 4; i++) tag_s[i*32 +: 32] = $urandom();
        for (int i = 0; i < 16; i++) beats[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        q.delete();
        {n_aad, n_blk, n_alast, n_blast, n_key, n_iv, n_init, n_tagv, n_done, n_viol} = '0;
        idx = 0; res_pend = 0; res_given = 0;
        saw_tr = 0; tag_fired = 0; aborted = 0; extra_done = !extra; tag_given = 0;

        iEncdec = enc; iKeylen = kl; iKey = key_s; iIV = iv_s;
        iAadCnt = CW'(aad); iBlkCnt = CW'(blk); iStart = 1'b1;
        iCoreReady = 1'b0; iData_valid = 1'b0; iTag_valid = 1'b0;
        iCoreResult_valid = 1'b0; iCoreTag_valid = 1'b0;
        sample();
        chk("busy_after_start", oBusy, 1);
        chk("err_clear_on_start", oErr, 0);
        // Scramble command inputs: only the latched copy may matter now.
        iStart = 1'b0; iKey = ~key_s; iIV = ~iv_s; iEncdec = !enc; iKeylen = !kl;
        iAadCnt = CW'(aad + 1); iBlkCnt = CW'(blk + 2);

        for (int cyc = 0; cyc < 400 && n_done == 0 && !aborted; cyc++) begin
            iCoreReady  = tgl ? (cyc % 2 == 0) : 1'b1;
            iData_valid = (idx < aad + blk);
            iData       = iData_valid ? beats[idx] : '0;
            iTag_valid  = !enc;
            iTag        = tag_s;
            iCoreResult_valid = 1'b0;
            iCoreTag_valid    = 1'b0;
            if (res_pend > 0) begin
                iCoreResult_valid = 1'b1; res_pend--; res_given++;
            end else if (!extra_done && res_given == blk && idx == aad + blk) begin
                iCoreResult_valid = 1'b1; extra_done = 1'b1;
            end else if (!tag_given && extra_done && res_given == blk && idx == aad + blk &&
                         (enc || tag_fired)) begin
                iCoreTag_valid = 1'b1; iCoreAuthentic = auth; tag_given = 1'b1;
            end
            iStart = glitch && cyc == 3;
            sample();
            if (abort_at >= 0 && n_blk == abort_at) aborted = 1'b1;
        end
        iStart = 1'b0;
        if (!aborted) begin
            chk("done_seen", n_done, 1);
            chk("aad_beats", n_aad, aad);
            chk("blk_beats", n_blk, blk);
            chk("last_flags", {32'(n_alast), 32'(n_blast)}, {32'(aad > 0), 32'(blk > 0)});
            chk("init_key_iv", {32'(n_init), 32'(n_key), 32'(n_iv)}, {32'd1, 32'd1, 32'd1});
            chk("core_tag_pulses", n_tagv, enc ? 0 : 1);
            chk("tag_ready_seen", saw_tr, !enc);
            chk("valid_discipline", n_viol, 0);
            chk("queue_empty", q.size(), 0);
            iData_valid = 1'b0; iTag_valid = 1'b0;
            iCoreResult_valid = 1'b0; iCoreTag_valid = 1'b0;
            repeat (3) sample();
            chk("single_done", n_done, 1);
            chk("idle_not_busy", oBusy, 0);
            chk("err_sticky", oErr, exp_err);
        end
    endtask

    initial begin
        iRstn = 1'b0;
        repeat (2) @(posedge iClk);
        #1;
        chk_zero("por");
        iRstn = 1'b1;
        sample();

        // Encrypt, 2 AAD + 3 payload, core always ready
        run_op(1, 1, 2, 3, 0, 0, 0, 0, -1);
        // Decrypt, no AAD, one block, tag rejected by the core
        run_op(0, 0, 0, 1, 0, 0, 0, 0, -1);
        // Core ready toggling every cycle
        run_op(0, 1, 1, 4, 1, 1, 0, 0, -1);
        // Reset after 2 of 5 payload blocks, then a fresh command
        run_op(1, 0, 3, 5, 0, 0, 0, 0, 2);
        iRstn = 1'b0;
        #1;
        chk_zero("mid_rst");
        iData_valid = 1'b0; iTag_valid = 1'b0; iCoreResult_valid = 1'b0; iCoreTag_valid = 1'b0;
        repeat (2) @(posedge iClk);
        #1;
        iRstn = 1'b1;
        run_op(1, 1, 1, 2, 0, 0, 0, 0, -1);
        // Surplus core result raises the sticky error
        run_op(1, 0, 0, 2, 0, 0, 1, 0, -1);
        // Next command clears it; decrypt with AAD only, no payload
        run_op(0, 0, 2, 0, 1, 0, 0, 0, -1);
        // Start strobe while busy must be ignored
        run_op(1, 1, 1, 2, 0, 0, 0, 1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
